// File: rtl/matrix_access_arbiter.sv
// ---------------------------------------------------------------------------
// matrix_access_arbiter
//
// Shares the single matrix storage bank between two writers (manual input
// unit, random generator) and two readers (display, compute). Level req/ack
// handshakes from the units become one-cycle store/read strobes towards the
// bank. Only one bank operation is in flight at a time. Stores take priority
// over reads. A store is refused when the bank is already full.
//
// Optional feature: define ARB_STATS_EN to add saturating event counters
// (stat_store_o, stat_rej_o, stat_read_o).
//
// Ports
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   in_req_i/in_m_i/in_n_i/in_data_i   input unit store request + matrix
//   in_ack_o/in_rej_o               input unit: stored / refused (1-cycle)
//   gen_*                           same set for the generator
//   st_in_en_o/st_gen_en_o          bank store strobes (one per source)
//   st_m_o/st_n_o/st_data_o         matrix presented to the bank
//   st_count_i                      bank occupancy
//   dsp_req_i/dsp_idx_i             display read request + slot index
//   cmp_req_i/cmp_idx_i             compute read request + slot index
//   rd_en_o/rd_idx_o                bank read strobe + slot index
//   rd_done_i/rd_valid_i            bank read finished / slot populated
//   dsp_ack_o/cmp_ack_o             read data valid for that reader
//   rd_hit_o                        qualifies the read ack (0 = empty/timeout)
// ---------------------------------------------------------------------------
module matrix_access_arbiter #(
    parameter int DATA_W   = 200,
    parameter int DIM_W    = 4,
    parameter int IDX_W    = 4,
    parameter int CAPACITY = 10,
    parameter int RD_TMO   = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef ARB_STATS_EN
    output logic [7:0]        stat_store_o,
    output logic [7:0]        stat_rej_o,
    output logic [7:0]        stat_read_o,
`endif
    input  logic              in_req_i,
    input  logic [DIM_W-1:0]  in_m_i,
    input  logic [DIM_W-1:0]  in_n_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ack_o,
    output logic              in_rej_o,
    input  logic              gen_req_i,
    input  logic [DIM_W-1:0]  gen_m_i,
    input  logic [DIM_W-1:0]  gen_n_i,
    input  logic [DATA_W-1:0] gen_data_i,
    output logic              gen_ack_o,
    output logic              gen_rej_o,
    output logic              st_in_en_o,
    output logic              st_gen_en_o,
    output logic [DIM_W-1:0]  st_m_o,
    output logic [DIM_W-1:0]  st_n_o,
    output logic [DATA_W-1:0] st_data_o,
    input  logic [3:0]        st_count_i,
    input  logic              dsp_req_i,
    input  logic [IDX_W-1:0]  dsp_idx_i,
    input  logic              cmp_req_i,
    input  logic [IDX_W-1:0]  cmp_idx_i,
    output logic              rd_en_o,
    output logic [IDX_W-1:0]  rd_idx_o,
    input  logic              rd_done_i,
    input  logic              rd_valid_i,
    output logic              dsp_ack_o,
    output logic              cmp_ack_o,
    output logic              rd_hit_o
);

    localparam int TMO_W = $clog2(RD_TMO + 1);

    typedef enum logic [2:0] {IDLE, ST_ISSUE, ST_SETTLE, RD_ISSUE, RD_WAIT} state_t;

    state_t              state_q, state_d;
    logic                storePtr_q, storePtr_d;
    logic                readPtr_q, readPtr_d;
    logic                storeOwner_q, storeOwner_d;
    logic                readOwner_q, readOwner_d;
    logic [DIM_W-1:0]    stM_q, stM_d, stN_q, stN_d;
    logic [DATA_W-1:0]   stData_q, stData_d;
    logic [IDX_W-1:0]    rdIdx_q, rdIdx_d;
    logic                stInEn_q, stInEn_d, stGenEn_q, stGenEn_d, rdEn_q, rdEn_d;
    logic                inAck_q, inAck_d, genAck_q, genAck_d;
    logic                inRej_q, inRej_d, genRej_q, genRej_d;
    logic [TMO_W-1:0]    tmoCnt_q, tmoCnt_d;

    logic inPend, genPend, pickGen, pickCmp, bankFull, readDone;

    // A writer whose ack/rej is on the wire this cycle still has req high;
    // that is the tail of the finished handshake, not a fresh request.
    assign inPend   = in_req_i  & ~inAck_q  & ~inRej_q;
    assign genPend  = gen_req_i & ~genAck_q & ~genRej_q;
    assign pickGen  = genPend & (~inPend | storePtr_q);
    assign pickCmp  = cmp_req_i & (~dsp_req_i | readPtr_q);
    assign bankFull = 32'(st_count_i) >= 32'(CAPACITY);

    // A read finishes when the bank answers, or when the wait counter runs
    // out, whichever comes first; a real answer wins a tie.
    assign readDone = (state_q == RD_WAIT) &&
                      (rd_done_i || (tmoCnt_q == TMO_W'(RD_TMO)));

    // Next-state and registered-output decode. Strobes and store acks are
    // produced one cycle after the state that requests them, so the store
    // strobe is seen during ST_SETTLE and the bank count has already moved
    // by the time the ack reaches the writer and the FSM is back in IDLE.
    always_comb begin
        state_d      = state_q;
        storePtr_d   = storePtr_q;
        readPtr_d    = readPtr_q;
        storeOwner_d = storeOwner_q;
        readOwner_d  = readOwner_q;
        stM_d        = stM_q;
        stN_d        = stN_q;
        stData_d     = stData_q;
        rdIdx_d      = rdIdx_q;
        tmoCnt_d     = tmoCnt_q;
        stInEn_d     = 1'b0;
        stGenEn_d    = 1'b0;
        rdEn_d       = 1'b0;
        inAck_d      = 1'b0;
        genAck_d     = 1'b0;
        inRej_d      = 1'b0;
        genRej_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (inPend || genPend) begin
                    storePtr_d = ~storePtr_q;
                    if (bankFull) begin
                        inRej_d  = ~pickGen;
                        genRej_d = pickGen;
                    end else begin
                        storeOwner_d = pickGen;
                        stM_d        = pickGen ? gen_m_i    : in_m_i;
                        stN_d        = pickGen ? gen_n_i    : in_n_i;
                        stData_d     = pickGen ? gen_data_i : in_data_i;
                        state_d      = ST_ISSUE;
                    end
                end else if (dsp_req_i || cmp_req_i) begin
                    readPtr_d   = ~readPtr_q;
                    readOwner_d = pickCmp;
                    rdIdx_d     = pickCmp ? cmp_idx_i : dsp_idx_i;
                    state_d     = RD_ISSUE;
                end
            end
            ST_ISSUE: begin
                stInEn_d  = ~storeOwner_q;
                stGenEn_d = storeOwner_q;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                inAck_d  = ~storeOwner_q;
                genAck_d = storeOwner_q;
                state_d  = IDLE;
            end
            RD_ISSUE: begin
                rdEn_d   = 1'b1;
                tmoCnt_d = '0;
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                tmoCnt_d = tmoCnt_q + TMO_W'(1);
                if (readDone) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset abandons any transaction in flight
    // immediately, so no strobe, ack or reject survives it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            storePtr_q   <= 1'b0;
            readPtr_q    <= 1'b0;
            storeOwner_q <= 1'b0;
            readOwner_q  <= 1'b0;
            stM_q        <= '0;
            stN_q        <= '0;
            stData_q     <= '0;
            rdIdx_q      <= '0;
            tmoCnt_q     <= '0;
            stInEn_q     <= 1'b0;
            stGenEn_q    <= 1'b0;
            rdEn_q       <= 1'b0;
            inAck_q      <= 1'b0;
            genAck_q     <= 1'b0;
            inRej_q      <= 1'b0;
            genRej_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            storePtr_q   <= storePtr_d;
            readPtr_q    <= readPtr_d;
            storeOwner_q <= storeOwner_d;
            readOwner_q  <= readOwner_d;
            stM_q        <= stM_d;
            stN_q        <= stN_d;
            stData_q     <= stData_d;
            rdIdx_q      <= rdIdx_d;
            tmoCnt_q     <= tmoCnt_d;
            stInEn_q     <= stInEn_d;
            stGenEn_q    <= stGenEn_d;
            rdEn_q       <= rdEn_d;
            inAck_q      <= inAck_d;
            genAck_q     <= genAck_d;
            inRej_q      <= inRej_d;
            genRej_q     <= genRej_d;
        end
    end

    assign st_in_en_o  = stInEn_q;
    assign st_gen_en_o = stGenEn_q;
    assign st_m_o      = stM_q;
    assign st_n_o      = stN_q;
    assign st_data_o   = stData_q;
    assign rd_en_o     = rdEn_q;
    assign rd_idx_o    = rdIdx_q;
    assign in_ack_o    = inAck_q;
    assign in_rej_o    = inRej_q;
    assign gen_ack_o   = genAck_q;
    assign gen_rej_o   = genRej_q;
    // Read acks coincide with the bank's read outputs, so they are not delayed.
    assign dsp_ack_o   = readDone & ~readOwner_q;
    assign cmp_ack_o   = readDone & readOwner_q;
    assign rd_hit_o    = readDone & rd_done_i & rd_valid_i;

`ifdef ARB_STATS_EN
    logic [7:0] statStore_q, statStore_d, statRej_q, statRej_d, statRead_q, statRead_d;

    // Event counters stick at their maximum instead of wrapping.
    always_comb begin
        statStore_d = statStore_q;
        statRej_d   = statRej_q;
        statRead_d  = statRead_q;
        if ((inAck_q || genAck_q) && statStore_q != 8'hFF) statStore_d = statStore_q + 8'd1;
        if ((inRej_q || genRej_q) && statRej_q   != 8'hFF) statRej_d   = statRej_q + 8'd1;
        if (readDone && statRead_q != 8'hFF)                statRead_d  = statRead_q + 8'd1;
    end

    // Counter registers, cleared with the rest of the arbiter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            statStore_q <= '0;
            statRej_q   <= '0;
            statRead_q  <= '0;
        end else begin
            statStore_q <= statStore_d;
            statRej_q   <= statRej_d;
            statRead_q  <= statRead_d;
        end
    end

    assign stat_store_o = statStore_q;
    assign stat_rej_o   = statRej_q;
    assign stat_read_o  = statRead_q;
`endif

endmodule

// File: tb/tb_matrix_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_matrix_access_arbiter
//
// Drives groups of simultaneous requests into the arbiter and compares every
// cycle against a transaction schedule built from the handshake latencies:
// store grant -> strobe 2 cycles later, ack 3 cycles later; full bank ->
// reject next cycle; read grant -> rd_en 2 cycles later, ack when the bank
// answers (next cycle) or RD_TMO cycles after the wait begins.
// A small bank model answers reads and tracks the matrix count.
// ---------------------------------------------------------------------------
module tb_matrix_access_arbiter;

    localparam int DATA_W   = 200;
    localparam int DIM_W    = 4;
    localparam int IDX_W    = 4;
    localparam int CAPACITY = 10;
    localparam int RD_TMO   = 15;
    localparam int MAXC     = 80;

    localparam int P_SIN  = 0;
    localparam int P_SGEN = 1;
    localparam int P_RD   = 2;
    localparam int P_IACK = 3;
    localparam int P_IREJ = 4;
    localparam int P_GACK = 5;
    localparam int P_GREJ = 6;
    localparam int P_DACK = 7;
    localparam int P_CACK = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              in_req_i, gen_req_i, dsp_req_i, cmp_req_i;
    logic [DIM_W-1:0]  in_m_i, in_n_i, gen_m_i, gen_n_i;
    logic [DATA_W-1:0] in_data_i, gen_data_i;
    logic              in_ack_o, in_rej_o, gen_ack_o, gen_rej_o;
    logic              st_in_en_o, st_gen_en_o;
    logic [DIM_W-1:0]  st_m_o, st_n_o;
    logic [DATA_W-1:0] st_data_o;
    logic [3:0]        st_count_i;
    logic [IDX_W-1:0]  dsp_idx_i, cmp_idx_i, rd_idx_o;
    logic              rd_en_o, rd_done_i, rd_valid_i;
    logic              dsp_ack_o, cmp_ack_o, rd_hit_o;
`ifdef ARB_STATS_EN
    logic [7:0]        stat_store_o, stat_rej_o, stat_read_o;
`endif

    int checks   = 0;
    int failures = 0;

    bit storePtrM;
    bit readPtrM;
    int bankCount;
    bit populated [16];
    int expStore, expRej, expRead;

    always #5 clk_i = ~clk_i;

    matrix_access_arbiter #(
        .DATA_W(DATA_W), .DIM_W(DIM_W), .IDX_W(IDX_W),
        .CAPACITY(CAPACITY), .RD_TMO(RD_TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
`ifdef ARB_STATS_EN
        .stat_store_o(stat_store_o), .stat_rej_o(stat_rej_o), .stat_read_o(stat_read_o),
`endif
        .in_req_i(in_req_i), .in_m_i(in_m_i), .in_n_i(in_n_i), .in_data_i(in_data_i),
        .in_ack_o(in_ack_o), .in_rej_o(in_rej_o),
        .gen_req_i(gen_req_i), .gen_m_i(gen_m_i), .gen_n_i(gen_n_i), .gen_data_i(gen_data_i),
        .gen_ack_o(gen_ack_o), .gen_rej_o(gen_rej_o),
        .st_in_en_o(st_in_en_o), .st_gen_en_o(st_gen_en_o),
        .st_m_o(st_m_o), .st_n_o(st_n_o), .st_data_o(st_data_o), .st_count_i(st_count_i),
        .dsp_req_i(dsp_req_i), .dsp_idx_i(dsp_idx_i),
        .cmp_req_i(cmp_req_i), .cmp_idx_i(cmp_idx_i),
        .rd_en_o(rd_en_o), .rd_idx_o(rd_idx_o), .rd_done_i(rd_done_i), .rd_valid_i(rd_valid_i),
        .dsp_ack_o(dsp_ack_o), .cmp_ack_o(cmp_ack_o), .rd_hit_o(rd_hit_o)
    );

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [8:0] samplePulses();
        return {cmp_ack_o, dsp_ack_o, gen_rej_o, gen_ack_o, in_rej_o, in_ack_o,
                rd_en_o, st_gen_en_o, st_in_en_o};
    endfunction

    function automatic logic [DATA_W-1:0] randomData();
        logic [223:0] tmp;
        tmp = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom()};
        return tmp[DATA_W-1:0];
    endfunction

    task automatic idleInputs();
        in_req_i = 1'b0; gen_req_i = 1'b0; dsp_req_i = 1'b0; cmp_req_i = 1'b0;
        rd_done_i = 1'b0; rd_valid_i = 1'b0;
    endtask

    // One scenario: the chosen requesters all raise req in cycle 0 and each
    // holds it until it sees its own ack/reject.
    task automatic applyStimulus(input bit rIn, input bit rGen, input bit rDsp, input bit rCmp,
                                 input int count0, input logic [DIM_W-1:0] mIn,
                                 input logic [DIM_W-1:0] nIn, input logic [IDX_W-1:0] iD,
                                 input logic [IDX_W-1:0] iC, input bit tmo);
        logic [8:0]        expPulse [MAXC];
        bit                expHit   [MAXC];
        logic [DIM_W-1:0]  expM     [MAXC];
        logic [DIM_W-1:0]  expN     [MAXC];
        logic [DATA_W-1:0] expData  [MAXC];
        logic [IDX_W-1:0]  expIdx   [MAXC];
        logic [DATA_W-1:0] dIn, dGen;
        logic [DIM_W-1:0]  mGen, nGen;
        logic [IDX_W-1:0]  idx, prevIdx;
        logic [8:0]        obs, prevObs;
        bit                pend [4];
        int                t, cnt, src, ackT;

        dIn  = randomData();
        dGen = randomData();
        mGen = DIM_W'($urandom_range(1, 5));
        nGen = DIM_W'($urandom_range(1, 5));
        for (int i = 0; i < MAXC; i++) begin
            expPulse[i] = '0; expHit[i] = 1'b0; expM[i] = '0; expN[i] = '0;
            expData[i] = '0; expIdx[i] = '0;
        end

        pend[0] = rIn; pend[1] = rGen; pend[2] = rDsp; pend[3] = rCmp;
        t = 0;
        cnt = count0;
        while (pend[0] || pend[1] || pend[2] || pend[3]) begin
            if (pend[0] || pend[1]) begin
                src = (pend[0] && pend[1]) ? int'(storePtrM) : (pend[1] ? 1 : 0);
                storePtrM = !storePtrM;
                pend[src] = 1'b0;
                if (cnt >= CAPACITY) begin
                    expPulse[t+1][src == 1 ? P_GREJ : P_IREJ] = 1'b1;
                    expRej++;
                    t = t + 1;
                end else begin
                    expPulse[t+2][src == 1 ? P_SGEN : P_SIN] = 1'b1;
                    expM[t+2]    = (src == 1) ? mGen : mIn;
                    expN[t+2]    = (src == 1) ? nGen : nIn;
                    expData[t+2] = (src == 1) ? dGen : dIn;
                    expPulse[t+3][src == 1 ? P_GACK : P_IACK] = 1'b1;
                    cnt++;
                    expStore++;
                    t = t + 3;
                end
            end else begin
                src = (pend[2] && pend[3]) ? 2 + int'(readPtrM) : (pend[3] ? 3 : 2);
                readPtrM = !readPtrM;
                pend[src] = 1'b0;
                idx = (src == 3) ? iC : iD;
                expPulse[t+2][P_RD] = 1'b1;
                expIdx[t+2] = idx;
                ackT = tmo ? t + 2 + RD_TMO : t + 3;
                expPulse[ackT][src == 3 ? P_CACK : P_DACK] = 1'b1;
                expHit[ackT] = tmo ? 1'b0 : populated[idx];
                expRead++;
                t = ackT + 1;
            end
        end

        bankCount = count0;
        prevObs = '0;
        prevIdx = '0;
        for (int c = 0; c <= t + 2; c++) begin
            @(posedge clk_i);
            #1;
            if (c == 0) begin
                in_req_i = rIn; gen_req_i = rGen; dsp_req_i = rDsp; cmp_req_i = rCmp;
                in_m_i = mIn; in_n_i = nIn; in_data_i = dIn;
                gen_m_i = mGen; gen_n_i = nGen; gen_data_i = dGen;
                dsp_idx_i = iD; cmp_idx_i = iC;
            end else begin
                if (prevObs[P_IACK] || prevObs[P_IREJ]) in_req_i  = 1'b0;
                if (prevObs[P_GACK] || prevObs[P_GREJ]) gen_req_i = 1'b0;
                if (prevObs[P_DACK]) dsp_req_i = 1'b0;
                if (prevObs[P_CACK]) cmp_req_i = 1'b0;
            end
            if ((prevObs[P_SIN] || prevObs[P_SGEN]) && bankCount < 15) bankCount++;
            st_count_i = 4'(bankCount);
            rd_done_i  = prevObs[P_RD] && !tmo;
            rd_valid_i = tmo ? 1'b1 : (prevObs[P_RD] ? populated[prevIdx] : 1'b0);

            @(negedge clk_i);
            obs = samplePulses();
            checkOutput($sformatf("pulses c%0d", c), 256'(obs), 256'(expPulse[c]));
            if (expPulse[c][P_SIN] || expPulse[c][P_SGEN]) begin
                checkOutput($sformatf("st_m c%0d", c), 256'(st_m_o), 256'(expM[c]));
                checkOutput($sformatf("st_n c%0d", c), 256'(st_n_o), 256'(expN[c]));
                checkOutput($sformatf("st_data c%0d", c), 256'(st_data_o), 256'(expData[c]));
            end
            if (expPulse[c][P_RD])
                checkOutput($sformatf("rd_idx c%0d", c), 256'(rd_idx_o), 256'(expIdx[c]));
            if (expPulse[c][P_DACK] || expPulse[c][P_CACK])
                checkOutput($sformatf("rd_hit c%0d", c), 256'(rd_hit_o), 256'(expHit[c]));
            prevObs = obs;
            prevIdx = rd_idx_o;
        end
        @(posedge clk_i);
        #1;
        idleInputs();
    endtask

    task automatic resetDut();
        rst_i = 1'b1;
        idleInputs();
        storePtrM = 1'b0;
        readPtrM  = 1'b0;
        expStore = 0; expRej = 0; expRead = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("reset pulses", 256'(samplePulses()), 256'(0));
        checkOutput("reset st_m", 256'(st_m_o), 256'(0));
        checkOutput("reset st_data", 256'(st_data_o), 256'(0));
        checkOutput("reset rd_idx", 256'(rd_idx_o), 256'(0));
        checkOutput("reset rd_hit", 256'(rd_hit_o), 256'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Reset lands while the input store strobe is on the bus.
    task automatic midOpReset();
        st_count_i = 4'd0;
        @(posedge clk_i);
        #1;
        in_req_i = 1'b1; in_m_i = 4'd3; in_n_i = 4'd3; in_data_i = randomData();
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        checkOutput("midrst strobe before", 256'(st_in_en_o), 256'(1));
        rst_i = 1'b1;
        #1;
        checkOutput("midrst pulses", 256'(samplePulses()), 256'(0));
        checkOutput("midrst st_m", 256'(st_m_o), 256'(0));
`ifdef ARB_STATS_EN
        checkOutput("midrst stat_store", 256'(stat_store_o), 256'(0));
        checkOutput("midrst stat_rej", 256'(stat_rej_o), 256'(0));
        checkOutput("midrst stat_read", 256'(stat_read_o), 256'(0));
`endif
        in_req_i = 1'b0;
        storePtrM = 1'b0;
        readPtrM  = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checkOutput($sformatf("midrst quiet %0d", i), 256'(samplePulses()), 256'(0));
        end
    endtask

    initial begin
        in_m_i = '0; in_n_i = '0; in_data_i = '0;
        gen_m_i = '0; gen_n_i = '0; gen_data_i = '0;
        dsp_idx_i = '0; cmp_idx_i = '0; st_count_i = '0;
        for (int i = 0; i < 16; i++) populated[i] = 1'($urandom_range(0, 1));
        populated[4] = 1'b1;
        populated[1] = 1'b0;

        resetDut();

        // Both writers at once after reset: input first, then generator.
        applyStimulus(1, 1, 0, 0, 0, 4'd4, 4'd4, '0, '0, 0);
        // Lone input store of a 2x3 matrix into an empty bank.
        applyStimulus(1, 0, 0, 0, 0, 4'd2, 4'd3, '0, '0, 0);
        // Full bank: generator refused, pointer still moves on.
        applyStimulus(0, 1, 0, 0, CAPACITY, 4'd1, 4'd1, '0, '0, 0);
        applyStimulus(1, 1, 0, 0, CAPACITY - 1, 4'd5, 4'd5, '0, '0, 0);
        // Two readers at once, one populated slot and one empty slot.
        applyStimulus(0, 0, 1, 1, 0, 4'd1, 4'd1, 4'd4, 4'd1, 0);
        // Bank never answers: compute read times out.
        applyStimulus(0, 0, 0, 1, 0, 4'd1, 4'd1, '0, 4'd7, 1);
        // Stores ahead of reads when everything arrives together.
        applyStimulus(1, 1, 1, 1, 3, 4'd2, 4'd2, 4'd4, 4'd1, 0);

        for (int k = 0; k < 30; k++) begin
            bit a, b, c, d;
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            if (!(a || b || c || d)) a = 1'b1;
            applyStimulus(a, b, c, d,
                          ($urandom_range(0, 2) == 0) ? CAPACITY : int'($urandom_range(0, CAPACITY)),
                          DIM_W'($urandom_range(1, 5)), DIM_W'($urandom_range(1, 5)),
                          IDX_W'($urandom_range(0, 15)), IDX_W'($urandom_range(0, 15)),
                          ($urandom_range(0, 4) == 0));
        end

`ifdef ARB_STATS_EN
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("stat_store", 256'(stat_store_o), 256'(expStore > 255 ? 255 : expStore));
        checkOutput("stat_rej", 256'(stat_rej_o), 256'(expRej > 255 ? 255 : expRej));
        checkOutput("stat_read", 256'(stat_read_o), 256'(expRead > 255 ? 255 : expRead));
`endif

        midOpReset();
        applyStimulus(1, 1, 0, 0, 0, 4'd3, 4'd2, '0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
